alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 32-bit ALU instance between N_REQ requesters. Each request carries
//  ALUctr, a and b. Arbitration is round-robin with a valid/ready request handshake.
//  One operation is in flight at a time. The registered result, zero and negative
//  flags are returned on a single response channel tagged with the requester id.
//  The block sits between the issue logic and the existing ALU datapath.
// PARAMETERS
//  N_REQ        2   number of requesters, 2..8
//  EXEC_CYCLES  1   cycles the operands are held on the ALU before capture, 1..15
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous reset, active-high
//  req_valid     in   N_REQ      per-requester request valid
//  req_ready     out  N_REQ      per-requester grant/accept, at most one bit high
//  req_ctr       in   4*N_REQ    ALUctr per requester, slice i = [4*i+3:4*i]
//  req_a         in   32*N_REQ   operand A per requester, slice i = [32*i+31:32*i]
//  req_b         in   32*N_REQ   operand B per requester
//  rsp_valid     out  1          response valid
//  rsp_ready     in   1          response consumer ready
//  rsp_id        out  IDW        requester index of the response, IDW = max(1, clog2(N_REQ))
//  rsp_result    out  32         registered ALU result
//  rsp_zero      out  1          (rsp_result == 0)
//  rsp_negative  out  1          rsp_result[31]
//  busy          out  1          high in EXEC or RESP
// BEHAVIOUR
//  Reset:
//   - state = IDLE, priority pointer = 0.
//   - rsp_valid, rsp_id, rsp_result, rsp_zero and rsp_negative = 0; busy = 0.
//   - req_ready = 0 while rst is high.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE:
//   - req_ready is combinational: the one-hot grant to the first valid requester,
//     searching from the pointer upward with wrap-around.
//   - req_ready is 0 when no req_valid is high.
//   - Handshake = req_valid[g] & req_ready[g]. On the handshake, capture ctr, a, b
//     and id = g, load cnt = EXEC_CYCLES-1, then go to EXEC.
//   - A requester keeps valid and payload stable until its handshake.
//  EXEC:
//   - The captured operands drive the ALU; req_ready = 0.
//   - If cnt != 0: decrement cnt and stay.
//   - If cnt == 0: register the ALU result, zero and negative, then go to RESP.
//  RESP:
//   - rsp_valid = 1. The payload is stable until the handshake; req_ready = 0.
//   - On rsp_ready: go to IDLE and set pointer = (id+1) mod N_REQ.
//  Latency and throughput:
//   - For a request handshake in cycle C, rsp_valid goes high in cycle
//     C+EXEC_CYCLES+1.
//   - Peak throughput is 1 op per EXEC_CYCLES+2 cycles.
//   - No request is accepted in the cycle of the response handshake.
//  Flags: taken from the ALU outputs and registered. They must equal
//   (result==0) and result[31]; a mismatch is a bug.
//  ALUctr: not decoded here and passed through unchanged. Undefined codes return
//   whatever the ALU produces.
//  Boundaries:
//   - Simultaneous valids: exactly one grant per IDLE cycle.
//   - Pointer wraps from N_REQ-1 to 0.
//   - rsp_valid held with rsp_ready low: the block stalls indefinitely and drops nothing.
//   - rst mid-EXEC or mid-RESP: the in-flight op is discarded, no response is emitted,
//     and the pointer returns to 0.
// STRUCTURE
//  alu_defs.vh:
//   - ALUctr encodings (ALU_ADD, ALU_SUB, ...).
//   - FSM state encodings (ST_IDLE, ST_EXEC, ST_RESP).
//  Sub-module rr_arbiter #(N):
//   - inputs: req, pointer; output: one-hot grant and its encoded index.
//   - purely combinational.
//  The existing ALU module is instantiated once inside. No other logic is shared.
// TESTING  (default parameters unless stated)
//  1. Single ADD: after reset, req0 sends ALU_ADD with a=5, b=3.
//     -> req_ready[0] is high for 1 cycle and rsp_valid rises 2 cycles after the handshake.
//     -> rsp_id=0, result=00000008, zero=0, negative=0.
//  2. SUB flags:
//     -> ALU_SUB 3-5: result=FFFFFFFE, negative=1, zero=0.
//     -> ALU_SUB 7-7: result=00000000, zero=1, negative=0.
//  3. Both requesters held valid from reset, rsp_ready=1.
//     -> Grants go 0,1,0,1, ...; each rsp_id matches its granted requester.
//  4. rsp_ready held low for 5 cycles in RESP.
//     -> rsp_valid and payload are stable, req_ready=0, busy=1.
//     -> On release, the next grant goes to the other requester.
//  5. rst pulsed during EXEC.
//     -> All outputs are 0 immediately; no response appears.
//     -> A following req1 ADD 1+1 returns 00000002 with rsp_id=1.
//  6. EXEC_CYCLES=3 instance, ALU_ADD FFFFFFFF+1.
//     -> rsp_valid rises 4 cycles after the handshake.
//     -> result=0, zero=1, negative=0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter.
//  - ALUctr encodings understood by the shared ALU
//  - FSM state type used by the arbiter top
package alu_share_arbiter_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_SLT  = 4'h6;
   localparam logic [3:0] ALU_SLTU = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the issue logic and the ALU share arbiter.
//  req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//  req_ctr/req_a/req_b : per-requester ALUctr and operands
//  rsp_*               : single tagged response channel, valid/ready handshake
//  busy                : arbiter has an operation in flight
// modport master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(parameter int N_REQ = 2);

   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0][3:0]  req_ctr;
   logic [N_REQ-1:0][31:0] req_a;
   logic [N_REQ-1:0][31:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [31:0]            rsp_result;
   logic                   rsp_zero;
   logic                   rsp_negative;
   logic                   busy;

   modport master (
      output req_valid, req_ctr, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, busy
   );

   modport slave (
      input  req_valid, req_ctr, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, busy
   );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// The 32-bit ALU datapath shared by all requesters. Purely combinational.
//  ctr      : ALUctr, undefined codes produce 0
//  a, b     : operands
//  result   : ALU output
//  zero     : result == 0
//  negative : result[31]
module alu
   import alu_share_arbiter_pkg::*;
(
   input  logic [3:0]  ctr,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero,
   output logic        negative
);

   always_comb begin
      result = '0;
      case (ctr)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'd0, a < b};
         ALU_SLL:  result = a << b[4:0];
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $signed(a) >>> b[4:0];
         default:  result = '0;
      endcase
   end

   assign zero     = (result == '0);
   assign negative = result[31];

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Round-robin arbiter, purely combinational.
//  req : request vector
//  ptr : index with highest priority this cycle
//  gnt : one-hot grant to the first request at or above ptr (wrapping), 0 if none
//  idx : encoded index of gnt (0 when no grant)
module rr_arbiter #(
   parameter int N   = 2,
   parameter int IDW = 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);

   // Walk offsets from farthest to nearest so the nearest active request
   // from ptr is the last assignment and therefore wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            gnt = '0;
            gnt[(int'(ptr) + k) % N] = 1'b1;
            idx = IDW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU between N_REQ requesters with round-robin arbitration.
// One operation is in flight at a time: IDLE accepts, EXEC holds the operands on
// the ALU for EXEC_CYCLES cycles, RESP presents the registered result until taken.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : request/response bundle (slave side), see alu_share_arbiter_if
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int EXEC_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave bus
);

   localparam int         IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t         state;
   logic [IDW-1:0] ptr, id, gnt_idx;
   logic [N_REQ-1:0] gnt;
   logic [3:0]     ctr, cnt;
   logic [31:0]    op_a, op_b, alu_y;
   logic           alu_zero, alu_neg;

   rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   alu u_alu (
      .ctr      (ctr),
      .a        (op_a),
      .b        (op_b),
      .result   (alu_y),
      .zero     (alu_zero),
      .negative (alu_neg)
   );

   // Grant is offered only while idle; forced low during reset.
   assign bus.req_ready = (state == ST_IDLE && !rst) ? gnt : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         ptr              <= '0;
         id               <= '0;
         ctr              <= '0;
         op_a             <= '0;
         op_b             <= '0;
         cnt              <= '0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_id       <= '0;
         bus.rsp_result   <= '0;
         bus.rsp_zero     <= 1'b0;
         bus.rsp_negative <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|(bus.req_valid & gnt)) begin
                  ctr      <= bus.req_ctr[gnt_idx];
                  op_a     <= bus.req_a[gnt_idx];
                  op_b     <= bus.req_b[gnt_idx];
                  id       <= gnt_idx;
                  cnt      <= CNT_INIT;
                  bus.busy <= 1'b1;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  bus.rsp_result   <= alu_y;
                  bus.rsp_zero     <= alu_zero;
                  bus.rsp_negative <= alu_neg;
                  bus.rsp_id       <= id;
                  bus.rsp_valid    <= 1'b1;
                  state            <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  ptr           <= (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a
// randomized run scored against a cycle-count/queue reference model.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.N_REQ(N)) bus ();
   alu_share_arbiter_if #(.N_REQ(N)) bus3 ();

   alu_share_arbiter #(.N_REQ(N), .EXEC_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   alu_share_arbiter #(.N_REQ(N), .EXEC_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      int sh;
      logic [31:0] r;
      sh = int'(b[4:0]);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA: begin
            r = a >> sh;
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            return r;
         end
         default:  return 32'd0;
      endcase
   endfunction

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.req_valid = '0;  bus.rsp_ready = 1'b0;
      bus3.req_valid = '0; bus3.rsp_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Issue one op on requester r and wait (bounded) for its response.
   task automatic run_op(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int id,
                         output logic [31:0] res, output logic z, output logic n);
      int k;
      @(posedge clk); #1;
      bus.req_ctr[r] = op; bus.req_a[r] = a; bus.req_b[r] = b;
      bus.req_valid[r] = 1'b1; bus.rsp_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (!(bus.req_valid[r] && bus.req_ready[r]) && k < 20) begin
         @(negedge clk); k++;
      end
      @(posedge clk); #1;
      bus.req_valid[r] = 1'b0;
      lat = 1;
      @(negedge clk);
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk); lat++;
      end
      id = int'(bus.rsp_id); res = bus.rsp_result; z = bus.rsp_zero; n = bus.rsp_negative;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '1; bus3.req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b00) begin errors++;
         $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
      checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_zero, bus.rsp_negative} !== 4'b0) begin errors++;
         $display("FAIL reset_flags got=%b exp=0000", {bus.rsp_valid, bus.busy, bus.rsp_zero, bus.rsp_negative}); end
      checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_id !== 1'b0) begin errors++;
         $display("FAIL reset_payload got=%h/%0d exp=0/0", bus.rsp_result, bus.rsp_id); end
      bus.req_valid = '0; bus3.req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      @(posedge clk); #1;
      bus.req_ctr[0] = ALU_ADD; bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd3;
      bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b01) begin errors++;
         $display("FAIL add_grant got=%b exp=01", bus.req_ready); end
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++;
         $display("FAIL add_exec got=rdy%b v%b b%b exp=rdy00 v0 b1", bus.req_ready, bus.rsp_valid, bus.busy); end
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++;
         $display("FAIL add_latency got=%b exp=1", bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h8 || bus.rsp_zero !== 1'b0 ||
                    bus.rsp_negative !== 1'b0) begin errors++;
         $display("FAIL add_payload got=%0d %h z%b n%b exp=0 00000008 z0 n0", bus.rsp_id,
                  bus.rsp_result, bus.rsp_zero, bus.rsp_negative); end
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++;
         $display("FAIL add_no_accept_at_rsp got=%b exp=00", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0; bus.rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
         $display("FAIL add_done got=v%b b%b exp=v0 b0", bus.rsp_valid, bus.busy); end
   endtask

   task automatic test_sub_flags();
      int lat, id; logic [31:0] res; logic z, n;
      run_op(0, ALU_SUB, 32'd3, 32'd5, lat, id, res, z, n);
      checks++; if (lat != 2) begin errors++; $display("FAIL sub_neg_latency got=%0d exp=2", lat); end
      checks++; if (id != 0 || res !== 32'hFFFF_FFFE || z !== 1'b0 || n !== 1'b1) begin errors++;
         $display("FAIL sub_neg got=%0d %h z%b n%b exp=0 fffffffe z0 n1", id, res, z, n); end
      run_op(1, ALU_SUB, 32'd7, 32'd7, lat, id, res, z, n);
      checks++; if (id != 1 || res !== 32'h0 || z !== 1'b1 || n !== 1'b0) begin errors++;
         $display("FAIL sub_zero got=%0d %h z%b n%b exp=1 00000000 z1 n0", id, res, z, n); end
   endtask

   // Randomized run against a reference model: a single in-flight op described
   // by its handshake cycle, expected tag and expected result.
   task automatic test_round_robin(input int cycles, input bit all_valid,
                                   input bit always_ready, input string tag);
      int m_ptr, hs, eid, gcount, drop, cyc, g;
      bit pend, exp_v;
      logic [N-1:0] exp_rdy;
      logic [31:0] eres;
      pulse_reset();
      m_ptr = 0; hs = 0; eid = 0; gcount = 0; drop = -1; cyc = 0; pend = 0; eres = '0;
      for (int t = 0; t < cycles; t++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (i == drop || bus.req_valid[i] == 1'b0) begin
               if (all_valid || $urandom_range(0, 2) == 0) begin
                  bus.req_valid[i] = 1'b1;
                  bus.req_ctr[i] = 4'($urandom_range(0, 15));
                  bus.req_a[i] = $urandom; bus.req_b[i] = $urandom;
               end else begin
                  bus.req_valid[i] = 1'b0;
               end
            end
         end
         drop = -1;
         bus.rsp_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
         exp_rdy = '0;
         g = -1;
         if (!pend) for (int k = 0; k < N; k++)
            if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         if (g >= 0) exp_rdy[g] = 1'b1;
         exp_v = pend && (cyc >= hs + 2);
         checks++; if (bus.req_ready !== exp_rdy) begin errors++;
            $display("FAIL %s_grant cyc=%0d got=%b exp=%b", tag, cyc, bus.req_ready, exp_rdy); end
         checks++; if (bus.busy !== 1'(pend && cyc > hs)) begin errors++;
            $display("FAIL %s_busy cyc=%0d got=%b exp=%b", tag, cyc, bus.busy, pend && cyc > hs); end
         checks++; if (bus.rsp_valid !== 1'(exp_v)) begin errors++;
            $display("FAIL %s_rsp_valid cyc=%0d got=%b exp=%b", tag, cyc, bus.rsp_valid, exp_v); end
         if (exp_v) begin
            checks++;
            if (int'(bus.rsp_id) != eid || bus.rsp_result !== eres || bus.rsp_zero !== 1'(eres == 0) ||
                bus.rsp_negative !== eres[31]) begin errors++;
               $display("FAIL %s_payload cyc=%0d got=%0d %h z%b n%b exp=%0d %h", tag, cyc, bus.rsp_id,
                        bus.rsp_result, bus.rsp_zero, bus.rsp_negative, eid, eres); end
         end
         if (exp_v && bus.rsp_ready) begin
            pend = 0; m_ptr = (eid + 1) % N;
         end else if (g >= 0) begin
            pend = 1; hs = cyc; eid = g; drop = g;
            eres = model_alu(bus.req_ctr[g], bus.req_a[g], bus.req_b[g]);
            if (all_valid) begin
               checks++; if (g != gcount % N) begin errors++;
                  $display("FAIL %s_order got=%0d exp=%0d", tag, g, gcount % N); end
            end
            gcount++;
         end
      end
      checks++; if (gcount < 5) begin errors++;
         $display("FAIL %s_progress got=%0d exp>=5", tag, gcount); end
   endtask

   task automatic test_backpressure();
      int k;
      pulse_reset();
      @(posedge clk); #1;
      bus.req_ctr[0] = ALU_ADD; bus.req_a[0] = 32'd10;  bus.req_b[0] = 32'd20;
      bus.req_ctr[1] = ALU_SUB; bus.req_a[1] = 32'd100; bus.req_b[1] = 32'd1;
      bus.req_valid = 2'b11; bus.rsp_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (bus.rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      for (int t = 0; t < 5; t++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd30 ||
             bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL stall_hold t=%0d got=v%b id%0d %h rdy%b b%b exp=v1 id0 0000001e rdy00 b1",
                     t, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready, bus.busy); end
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b10) begin errors++;
         $display("FAIL stall_next_grant got=%b exp=10", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      k = 0;
      @(negedge clk);
      while (bus.rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'd99) begin errors++;
         $display("FAIL stall_second got=%0d %h exp=1 00000063", bus.rsp_id, bus.rsp_result); end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      int lat, id, got; logic [31:0] res; logic z, n;
      int ids[2]; logic [31:0] rs[2]; logic [N-1:0] hsm;
      pulse_reset();
      run_op(0, ALU_ADD, 32'd9, 32'd9, lat, id, res, z, n);   // leaves pointer at 1
      @(posedge clk); #1;
      bus.req_ctr[0] = ALU_ADD; bus.req_a[0] = 32'd4; bus.req_b[0] = 32'd4; bus.req_valid = 2'b01;
      @(negedge clk);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_exec got=%b exp=1", bus.busy); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00 ||
          bus.rsp_result !== 32'd0 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0 ||
          bus.rsp_negative !== 1'b0) begin errors++;
         $display("FAIL rst_async got=v%b b%b rdy%b %h id%0d exp=all zero", bus.rsp_valid, bus.busy,
                  bus.req_ready, bus.rsp_result, bus.rsp_id); end
      @(posedge clk); #1;
      rst = 1'b0; bus.rsp_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_no_rsp t=%0d got=%b exp=0", t, bus.rsp_valid); end
      end
      @(posedge clk); #1;
      bus.req_ctr[0] = ALU_ADD; bus.req_a[0] = 32'd2; bus.req_b[0] = 32'd3;
      bus.req_ctr[1] = ALU_ADD; bus.req_a[1] = 32'd1; bus.req_b[1] = 32'd1;
      bus.req_valid = 2'b11;
      @(negedge clk);
      checks++; if (bus.req_ready !== 2'b01) begin errors++;
         $display("FAIL rst_ptr got=%b exp=01", bus.req_ready); end
      got = 0; ids[0] = -1; ids[1] = -1; rs[0] = '0; rs[1] = '0;
      for (int t = 0; t < 20 && got < 2; t++) begin
         hsm = bus.req_valid & bus.req_ready;
         if (bus.rsp_valid && bus.rsp_ready) begin
            ids[got] = int'(bus.rsp_id); rs[got] = bus.rsp_result; got++;
         end
         @(posedge clk); #1;
         bus.req_valid = bus.req_valid & ~hsm;
         @(negedge clk);
      end
      checks++; if (got != 2 || ids[0] != 0 || rs[0] !== 32'd5) begin errors++;
         $display("FAIL rst_first got=%0d id%0d %h exp=2 id0 00000005", got, ids[0], rs[0]); end
      checks++; if (ids[1] != 1 || rs[1] !== 32'd2) begin errors++;
         $display("FAIL rst_req1_add got=id%0d %h exp=id1 00000002", ids[1], rs[1]); end
      bus.req_valid = '0; bus.rsp_ready = 1'b0;
   endtask

   task automatic test_exec3();
      int k, lat;
      pulse_reset();
      @(posedge clk); #1;
      bus3.req_ctr[0] = ALU_ADD; bus3.req_a[0] = 32'hFFFF_FFFF; bus3.req_b[0] = 32'd1;
      bus3.req_valid = 2'b01; bus3.rsp_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (!(bus3.req_valid[0] && bus3.req_ready[0]) && k < 20) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      bus3.req_valid = '0;
      lat = 1;
      @(negedge clk);
      while (bus3.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      checks++; if (lat != 4) begin errors++; $display("FAIL exec3_latency got=%0d exp=4", lat); end
      checks++; if (bus3.rsp_result !== 32'd0 || bus3.rsp_zero !== 1'b1 || bus3.rsp_negative !== 1'b0 ||
                    bus3.rsp_id !== 1'b0) begin errors++;
         $display("FAIL exec3_payload got=%h z%b n%b id%0d exp=00000000 z1 n0 id0", bus3.rsp_result,
                  bus3.rsp_zero, bus3.rsp_negative, bus3.rsp_id); end
      bus3.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus3.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid = '0;  bus.req_ctr = '0;  bus.req_a = '0;  bus.req_b = '0;  bus.rsp_ready = 1'b0;
      bus3.req_valid = '0; bus3.req_ctr = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b0;
      test_reset();
      test_single_add();
      test_sub_flags();
      test_round_robin(60, 1'b1, 1'b1, "rr_all");
      test_round_robin(200, 1'b0, 1'b0, "rr_rand");
      test_backpressure();
      test_reset_mid_exec();
      test_exec3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
